// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 16-bit SRAM between a 32-bit fetch port and an RV32I load/store port.
// Optional ARB_ROUND_ROBIN_EN: alternate winner on ties instead of fixed D-over-I priority.
module sram_port_arbiter #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              sw,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [31:0]       i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_funct3,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ack,
   output logic              busy,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] o_SRAM_DQ
);
   typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, RESP} state_t;
   state_t state_q, state_d;
   logic port_q, we_q, grant_d, legal, word, acc, wr, unused_hi_addr;
   logic [2:0] f3_q;
   logic [18:0] addr_q;
   logic [31:0] wdata_q, ld;
   logic [DATA_W-1:0] hi_q, lo_q, dout;
   assign unused_hi_addr = ^{i_addr[31:19], d_addr[31:19]};
`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q;
   assign grant_d = d_req & (~i_req | ~last_d_q);
`else
   assign grant_d = d_req;
`endif
   // fetches are latched as funct3=LW loads so they share the word path
   assign legal = we_q ? (f3_q < 3'd3) : (f3_q[1:0] != 2'b11 && f3_q != 3'd6);
   assign word  = legal && f3_q == 3'd2;
   assign acc   = state_q == ACC_HI || state_q == ACC_LO;
   assign wr    = acc && we_q && legal;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = (i_req | d_req) ? ACC_HI : IDLE;
         ACC_HI:  state_d = word ? ACC_LO : RESP;
         ACC_LO:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge sw) begin
      if (sw) begin
         state_q <= IDLE;
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && (i_req | d_req)) begin
            port_q  <= grant_d;
            we_q    <= grant_d & d_we;
            f3_q    <= grant_d ? d_funct3 : 3'd2;
            addr_q  <= grant_d ? d_addr[18:0] : i_addr[18:0];
            wdata_q <= grant_d ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= grant_d;
`endif
         end
         if (state_q == ACC_HI) hi_q <= o_SRAM_DQ;
         if (state_q == ACC_LO) lo_q <= o_SRAM_DQ;
      end
   end
   assign dout = f3_q == 3'd0 ? {wdata_q[7:0], 8'h00} :
                 (f3_q == 3'd1 || state_q == ACC_LO) ? wdata_q[15:0] : wdata_q[31:16];
   assign o_SRAM_DQ   = wr ? dout : 'z;
   assign o_SRAM_WE_N = ~wr;
   assign o_SRAM_OE_N = wr;
   assign o_SRAM_CE_N = 1'b0;
   assign o_SRAM_UB_N = 1'b0;
   assign o_SRAM_LB_N = wr && f3_q == 3'd0;
   assign o_SRAM_ADDR = acc ? ADDR_W'({addr_q, state_q == ACC_LO}) : '0;
   // byte lane is the upper half of the SRAM word (big-endian)
   assign ld = !legal          ? 32'h0 :
               f3_q == 3'd0    ? {{24{hi_q[15]}}, hi_q[15:8]} :
               f3_q == 3'd4    ? {24'h0, hi_q[15:8]} :
               f3_q == 3'd1    ? {{16{hi_q[15]}}, hi_q} :
               f3_q == 3'd5    ? {16'h0, hi_q} : {hi_q, lo_q};
   assign i_ack   = state_q == RESP && !port_q;
   assign d_ack   = state_q == RESP && port_q;
   assign i_rdata = i_ack ? {hi_q, lo_q} : 32'h0;
   assign d_rdata = (d_ack && !we_q) ? ld : 32'h0;
   assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of the SRAM arbiter against a behavioural SRAM.
module tb_sram_port_arbiter;
   logic clk = 0, sw = 1;
   logic i_req = 0, d_req = 0, d_we = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
   logic [2:0] d_funct3 = 0;
   logic [31:0] i_rdata, d_rdata;
   logic i_ack, d_ack, busy, we_n, ce_n, oe_n, lb_n, ub_n;
   logic [19:0] sa;
   wire [15:0] dq;
   logic [15:0] mem [0:255];
   int n_chk = 0, n_pass = 0;
   sram_port_arbiter dut (
      .clk(clk), .sw(sw),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy),
      .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
      .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n), .o_SRAM_ADDR(sa), .o_SRAM_DQ(dq)
   );
   always #5 clk = ~clk;
   assign dq = (!oe_n && we_n) ? mem[sa[7:0]] : 16'hzzzz;
   always @(posedge clk) begin
      if (!we_n && !ub_n) mem[sa[7:0]][15:8] = dq[15:8];
      if (!we_n && !lb_n) mem[sa[7:0]][7:0] = dq[7:0];
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic dreq(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1;
   endtask
   task automatic tie(input bit d_first);
      dreq(0, 3'd0, 32'h8, 0);
      i_addr = 32'h20; i_req = 1;
      if (d_first) begin
         tick(); tick();
         chk("tie_d_ack", d_ack, 1); chk("tie_i_wait", i_ack, 0);
         chk("tie_d_data", d_rdata, 32'hFFFFFF80);
         d_req = 0; tick();
         chk("tie_gap_idle", busy, 0);
         tick(); tick(); tick();
         chk("tie_i_ack", i_ack, 1); chk("tie_i_data", i_rdata, 32'h1234ABCD);
         i_req = 0; tick();
      end else begin
         tick(); tick(); tick();
         chk("tie_i_ack", i_ack, 1); chk("tie_d_wait", d_ack, 0);
         i_req = 0; tick();
         chk("tie_gap_idle", busy, 0);
         tick(); tick();
         chk("tie_d_ack", d_ack, 1); chk("tie_d_data", d_rdata, 32'hFFFFFF80);
         d_req = 0; tick();
      end
   endtask
   logic [2:0]  ld_f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
   logic [31:0] ld_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
   initial begin
      for (int k = 0; k < 256; k++) mem[k] = 16'h0;
      mem[8'h00] = 16'h0F0F; mem[8'h10] = 16'h80FF;
      mem[8'h40] = 16'h1234; mem[8'h41] = 16'hABCD; mem[8'h60] = 16'h1111;
      tick(); tick();
      chk("rst_busy", busy, 0); chk("rst_ack", {i_ack, d_ack}, 0);
      chk("rst_we_n", we_n, 1); chk("rst_oe_n", oe_n, 0); chk("rst_ce_n", ce_n, 0);
      chk("rst_lanes", {ub_n, lb_n}, 0); chk("rst_addr", sa, 0);
      chk("rst_rdata", i_rdata | d_rdata, 0);
      sw = 0;
      tie(1);
      i_addr = 32'h20; i_req = 1;
      tick(); chk("fetch_addr_hi", sa, 20'h40); chk("fetch_busy", busy, 1);
      tick(); chk("fetch_addr_lo", sa, 20'h41); chk("fetch_no_ack", i_ack, 0);
      tick(); chk("fetch_ack", i_ack, 1); chk("fetch_data", i_rdata, 32'h1234ABCD);
      i_req = 0;
      tick(); chk("fetch_ack_pulse", i_ack, 0); chk("fetch_idle", busy, 0);
      for (int k = 0; k < 4; k++) begin
         dreq(0, ld_f3[k], 32'h8, 0);
         tick(); chk("ld_addr", sa, 20'h10); chk("ld_oe_n", oe_n, 0);
         tick(); chk("ld_ack", d_ack, 1); chk("ld_data", d_rdata, ld_exp[k]);
         d_req = 0; tick();
      end
      dreq(1, 3'd0, 32'h30, 32'h000000A5);
      tick();
      chk("sb_we_n", we_n, 0); chk("sb_oe_n", oe_n, 1); chk("sb_dq", dq, 16'hA500);
      chk("sb_lanes", {ub_n, lb_n}, 2'b01); chk("sb_addr", sa, 20'h60);
      tick(); chk("sb_we_off", we_n, 1); chk("sb_ack", d_ack, 1);
      d_req = 0; tick();
      chk("sb_mem", mem[8'h60], 16'hA511);
      dreq(1, 3'd2, 32'h31, 32'hDEADBEEF);
      tick(); chk("sw_hi_dq", dq, 16'hDEAD); chk("sw_hi_addr", sa, 20'h62); chk("sw_hi_we", we_n, 0);
      tick(); chk("sw_lo_dq", dq, 16'hBEEF); chk("sw_lo_addr", sa, 20'h63); chk("sw_lo_lanes", {ub_n, lb_n}, 0);
      tick(); chk("sw_ack", d_ack, 1); chk("sw_we_off", we_n, 1);
      d_req = 0; tick();
      chk("sw_mem", {mem[8'h62], mem[8'h63]}, 32'hDEADBEEF);
      dreq(0, 3'd7, 32'h8, 0);
      tick(); chk("ill_we_n", we_n, 1);
      tick(); chk("ill_ack", d_ack, 1); chk("ill_data", d_rdata, 0);
      d_req = 0; tick();
`ifdef ARB_ROUND_ROBIN_EN
      tie(0);
`else
      tie(1);
`endif
      dreq(1, 3'd2, 32'h34, 32'h12345678);
      tick(); tick();
      chk("rst_mid_we", we_n, 0); chk("rst_mid_addr", sa, 20'h69);
      sw = 1; #1;
      chk("rst_async_we", we_n, 1); chk("rst_async_busy", busy, 0);
      chk("rst_async_addr", sa, 0); chk("rst_async_dq", dq, 16'h0F0F);
      tick(); chk("rst_no_ack", d_ack, 0);
      sw = 0;
      tick(); tick(); chk("reissue_lo_dq", dq, 16'h5678);
      tick(); chk("reissue_ack", d_ack, 1);
      d_req = 0; tick();
      chk("reissue_mem", {mem[8'h68], mem[8'h69]}, 32'h12345678);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
